// File: rtl/signal_conflict_monitor.sv
// Re-checks controller light codes at the lamp-driver side; the first fault latches a cause and
// forces flashing red until an operator clear. Define FAULT_CNT_EN to enable fault_count.
module signal_conflict_monitor #(
  parameter int unsigned        NCH          = 4,
  parameter logic [NCH*NCH-1:0] CONFLICT_MAP = 16'h084A,
  parameter int unsigned        MIN_YEL      = 3,
  parameter int unsigned        GLITCH_CYC   = 2,
  parameter int unsigned        FLASH_HALF   = 8,
  localparam int unsigned       CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3*NCH-1:0] lights_in,
  input  logic             fault_clr,
  output logic [3*NCH-1:0] lights_out,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CHW-1:0]   fault_chan,
  output logic [7:0]       fault_count
);

  localparam int unsigned YW = (MIN_YEL > 0) ? $clog2(MIN_YEL + 1) : 1;
  localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [2:0]       C_RED   = 3'b100;
  localparam logic [2:0]       C_YEL   = 3'b010;
  localparam logic [2:0]       C_GRN   = 3'b001;
  localparam logic [3*NCH-1:0] ALL_RED = {NCH{C_RED}};

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_INVALID  = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;

  typedef enum logic {ST_PASS = 1'b0, ST_FLASH = 1'b1} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3*NCH-1:0] r_samp;
  logic [2:0]       r_prev     [NCH];
  logic [NCH-1:0]   r_hist_vld;
  logic [YW-1:0]    r_yel_cnt  [NCH];
  logic [GW-1:0]    r_glitch   [NCH];
  logic [FW-1:0]    r_flash_cnt;
  logic [FW-1:0]    w_flash_cnt_nxt;
  logic             r_flash_on;
  logic             w_flash_on_nxt;
  logic [3*NCH-1:0] w_lights_nxt;
  logic [2:0]       w_code_nxt;
  logic [CHW-1:0]   w_chan_nxt;

  logic [2:0]       w_code     [NCH];
  logic [NCH-1:0]   w_vld;
  logic [NCH-1:0]   w_inv_flt;
  logic [NCH-1:0]   w_seq_flt;
  logic [NCH-1:0]   w_sy_flt;
  logic             w_det;
  logic [2:0]       w_det_code;
  logic [CHW-1:0]   w_det_chan;
  logic             w_clr;

  // Input stage: sampled unconditionally so checks always see the last presented value.
  always_ff @(posedge clk) begin
    r_samp <= lights_in;
  end

  // Per-head classification of the sampled code against its history.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      w_code[k]    = r_samp[3*k +: 3];
      w_vld[k]     = (w_code[k] == C_RED) || (w_code[k] == C_YEL) || (w_code[k] == C_GRN);
      w_inv_flt[k] = !w_vld[k] && ((32'(r_glitch[k]) + 32'd1) >= GLITCH_CYC);
      w_seq_flt[k] = w_vld[k] && r_hist_vld[k] && (w_code[k] != r_prev[k]) &&
                     !(((r_prev[k] == C_GRN) && (w_code[k] == C_YEL)) ||
                       ((r_prev[k] == C_YEL) && (w_code[k] == C_RED)) ||
                       ((r_prev[k] == C_RED) && (w_code[k] == C_GRN)));
      w_sy_flt[k]  = w_vld[k] && r_hist_vld[k] && (r_prev[k] == C_YEL) &&
                     (w_code[k] == C_RED) && (32'(r_yel_cnt[k]) < MIN_YEL);
    end
  end

  // Priority pick: conflict > invalid > sequence > short yellow, lowest index first.
  always_comb begin
    w_det      = 1'b0;
    w_det_code = FC_NONE;
    w_det_chan = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      for (int unsigned j = i + 1; j < NCH; j++) begin
        if (!w_det && CONFLICT_MAP[i*NCH+j] && w_vld[i] && w_vld[j] &&
            (w_code[i] != C_RED) && (w_code[j] != C_RED)) begin
          w_det      = 1'b1;
          w_det_code = FC_CONFLICT;
          w_det_chan = CHW'(i);
        end
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!w_det && w_inv_flt[k]) begin
        w_det      = 1'b1;
        w_det_code = FC_INVALID;
        w_det_chan = CHW'(k);
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!w_det && w_seq_flt[k]) begin
        w_det      = 1'b1;
        w_det_code = FC_SEQ;
        w_det_chan = CHW'(k);
      end
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!w_det && w_sy_flt[k]) begin
        w_det      = 1'b1;
        w_det_code = FC_SHORT_Y;
        w_det_chan = CHW'(k);
      end
    end
  end

  // A newly detected fault always beats a clear request in the same cycle.
  assign w_clr = fault_clr && (r_state == ST_FLASH) && (&w_vld) && !w_det;

  // Per-head history: last valid colour, yellow dwell and invalid run length.
  always_ff @(posedge clk) begin
    if (!rst || w_clr) begin
      r_hist_vld <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        r_prev[k]    <= C_RED;
        r_yel_cnt[k] <= '0;
        r_glitch[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (w_vld[k]) begin
          r_prev[k]     <= w_code[k];
          r_hist_vld[k] <= 1'b1;
          r_glitch[k]   <= '0;
          if (w_code[k] != C_YEL) begin
            r_yel_cnt[k] <= '0;
          end else if (32'(r_yel_cnt[k]) < MIN_YEL) begin
            r_yel_cnt[k] <= r_yel_cnt[k] + YW'(1);
          end
        end else if (32'(r_glitch[k]) < GLITCH_CYC) begin
          r_glitch[k] <= r_glitch[k] + GW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PASS:  if (w_det) w_state_nxt = ST_FLASH;
      ST_FLASH: if (w_clr) w_state_nxt = ST_PASS;
      default:  w_state_nxt = ST_PASS;
    endcase
  end

  // Next values for the registered outputs and the flash timer.
  always_comb begin
    w_lights_nxt    = r_samp;
    w_code_nxt      = fault_code;
    w_chan_nxt      = fault_chan;
    w_flash_cnt_nxt = r_flash_cnt;
    w_flash_on_nxt  = r_flash_on;
    case (r_state)
      ST_PASS: begin
        if (w_det) begin
          w_code_nxt      = w_det_code;
          w_chan_nxt      = w_det_chan;
          w_flash_cnt_nxt = '0;
          w_flash_on_nxt  = 1'b1;
          w_lights_nxt    = ALL_RED;
        end
      end
      ST_FLASH: begin
        if (w_clr) begin
          w_code_nxt = FC_NONE;
          w_chan_nxt = '0;
        end else begin
          if (32'(r_flash_cnt) == (FLASH_HALF - 32'd1)) begin
            w_flash_cnt_nxt = '0;
            w_flash_on_nxt  = !r_flash_on;
          end else begin
            w_flash_cnt_nxt = r_flash_cnt + FW'(1);
          end
          w_lights_nxt = w_flash_on_nxt ? ALL_RED : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lights_out  <= ALL_RED;
      fault_code  <= FC_NONE;
      fault_chan  <= '0;
      r_flash_cnt <= '0;
      r_flash_on  <= 1'b1;
    end else begin
      lights_out  <= w_lights_nxt;
      fault_code  <= w_code_nxt;
      fault_chan  <= w_chan_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
      r_flash_on  <= w_flash_on_nxt;
    end
  end

  assign fault = (r_state == ST_FLASH);

`ifdef FAULT_CNT_EN
  // Counts latch events (0->1 of fault), saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_count <= 8'd0;
    end else if ((r_state == ST_PASS) && w_det && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'd1;
    end
  end
`else
  assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: directed scenarios plus a randomized
// controller with fault injection, checked against a behavioural model.
module tb_signal_conflict_monitor;

  localparam int unsigned NCH        = 4;
  localparam int unsigned MIN_YEL    = 3;
  localparam int unsigned GLITCH_CYC = 2;
  localparam int unsigned FLASH_HALF = 8;
  localparam int unsigned CHW        = 2;
  localparam logic [15:0] CMAP       = 16'h084A;
  localparam logic [2:0]  R          = 3'b100;
  localparam logic [2:0]  Y          = 3'b010;
  localparam logic [2:0]  G          = 3'b001;
  localparam logic [11:0] ALLR       = {4{3'b100}};

  typedef struct packed {
    logic [3*NCH-1:0] lo;
    logic             f;
    logic [2:0]       code;
    logic [CHW-1:0]   chan;
    logic [7:0]       cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3*NCH-1:0] lights_in;
  logic             fault_clr;
  logic [3*NCH-1:0] lights_out;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CHW-1:0]   fault_chan;
  logic [7:0]       fault_count;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mcyc  = 0;

  // Behavioural model state
  logic             m_fault;
  logic [2:0]       m_code;
  logic [CHW-1:0]   m_chan;
  logic [7:0]       m_cnt;
  logic [11:0]      m_lights;
  logic [11:0]      m_samp;
  int               m_age;
  bit               has_last [NCH];
  logic [2:0]       last_col [NCH];
  int               y_run    [NCH];
  int               bad_run  [NCH];

  signal_conflict_monitor #(
    .NCH(NCH), .CONFLICT_MAP(CMAP), .MIN_YEL(MIN_YEL),
    .GLITCH_CYC(GLITCH_CYC), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .rst(rst), .lights_in(lights_in), .fault_clr(fault_clr),
    .lights_out(lights_out), .fault(fault), .fault_code(fault_code),
    .fault_chan(fault_chan), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  function automatic bit is_valid(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic bit is_legal(input logic [2:0] p, input logic [2:0] c);
    return ((p == G) && (c == Y)) || ((p == Y) && (c == R)) || ((p == R) && (c == G));
  endfunction

  function automatic logic [11:0] mk(input logic [2:0] h0, input logic [2:0] h1,
                                     input logic [2:0] h2, input logic [2:0] h3);
    return {h3, h2, h1, h0};
  endfunction

  task automatic forget_history();
    for (int k = 0; k < NCH; k++) begin
      has_last[k] = 1'b0;
      last_col[k] = R;
      y_run[k]    = 0;
      bad_run[k]  = 0;
    end
  endtask

  // Expected outputs after the coming edge, from the rules applied to the sampled word.
  task automatic model_edge(input logic [11:0] lin, input logic clr, input logic rv);
    exp_t       e;
    logic [2:0] c [NCH];
    int         dcode;
    int         dchan;
    bit         allv;
    bit         do_clr;
    if (!rv) begin
      m_fault  = 1'b0;
      m_code   = 3'd0;
      m_chan   = '0;
      m_cnt    = 8'd0;
      m_lights = ALLR;
      m_age    = 0;
      forget_history();
    end else begin
      dcode = 0;
      dchan = 0;
      allv  = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        c[k] = m_samp[3*k +: 3];
        if (!is_valid(c[k])) allv = 1'b0;
      end
      for (int i = 0; i < NCH; i++)
        for (int j = i + 1; j < NCH; j++)
          if (dcode == 0 && CMAP[i*NCH+j] && (c[i] == Y || c[i] == G) && (c[j] == Y || c[j] == G)) begin
            dcode = 1; dchan = i;
          end
      for (int k = 0; k < NCH; k++)
        if (dcode == 0 && !is_valid(c[k]) && bad_run[k] + 1 >= int'(GLITCH_CYC)) begin
          dcode = 2; dchan = k;
        end
      for (int k = 0; k < NCH; k++)
        if (dcode == 0 && is_valid(c[k]) && has_last[k] && c[k] != last_col[k] &&
            !is_legal(last_col[k], c[k])) begin
          dcode = 3; dchan = k;
        end
      for (int k = 0; k < NCH; k++)
        if (dcode == 0 && is_valid(c[k]) && has_last[k] && last_col[k] == Y && c[k] == R &&
            y_run[k] < int'(MIN_YEL)) begin
          dcode = 4; dchan = k;
        end
      do_clr = m_fault && clr && allv && (dcode == 0);
      if (do_clr) begin
        forget_history();
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (is_valid(c[k])) begin
            y_run[k]    = (c[k] == Y) ? y_run[k] + 1 : 0;
            has_last[k] = 1'b1;
            last_col[k] = c[k];
            bad_run[k]  = 0;
          end else begin
            bad_run[k]  = bad_run[k] + 1;
          end
        end
      end
      if (!m_fault) begin
        if (dcode != 0) begin
          m_fault  = 1'b1;
          m_code   = 3'(dcode);
          m_chan   = CHW'(dchan);
          m_age    = 0;
          m_lights = ALLR;
`ifdef FAULT_CNT_EN
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
`endif
        end else begin
          m_lights = m_samp;
        end
      end else if (do_clr) begin
        m_fault  = 1'b0;
        m_code   = 3'd0;
        m_chan   = '0;
        m_lights = m_samp;
      end else begin
        m_age    = m_age + 1;
        m_lights = (((m_age / int'(FLASH_HALF)) % 2) == 0) ? ALLR : 12'h000;
      end
    end
    m_samp = lin;
    e.lo   = m_lights;
    e.f    = m_fault;
    e.code = m_code;
    e.chan = m_chan;
    e.cnt  = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [11:0] lin, input logic clr, input logic rv);
    @(negedge clk);
    lights_in = lin;
    fault_clr = clr;
    rst       = rv;
    model_edge(lin, clr, rv);
  endtask

  task automatic hold(input logic [11:0] lin, input int n);
    for (int i = 0; i < n; i++) step(lin, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, mcyc, act, want);
    end
  endtask

  // Monitor: one expected record per clock edge once stimulus is running.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        mcyc++;
        chk("lights_out",  32'(lights_out),  32'(e.lo));
        chk("fault",       32'(fault),       32'(e.f));
        chk("fault_code",  32'(fault_code),  32'(e.code));
        chk("fault_chan",  32'(fault_chan),  32'(e.chan));
        chk("fault_count", 32'(fault_count), 32'(e.cnt));
      end
    end
  end

  task automatic rand_run(input int ncyc);
    int          grp   = 0;
    int          ph    = 2;
    int          left  = 2;
    int          age   = 0;
    int          inj_n = 0;
    int          inj_h = 0;
    logic [2:0]  inj_c = 3'd0;
    logic [2:0]  col;
    logic [11:0] w;
    logic        clr;
    logic        rv;
    for (int n = 0; n < ncyc; n++) begin
      clr = 1'b0;
      rv  = 1'b1;
      if (m_fault) begin
        w     = ALLR;
        age   = age + 1;
        clr   = ($urandom_range(0, 5) == 0);
        ph    = 2;
        left  = 1;
        inj_n = 0;
      end else begin
        age = 0;
        if (left == 0) begin
          if (ph == 0) begin
            ph = 1; left = $urandom_range(2, 6);
          end else if (ph == 1) begin
            ph = 2; left = $urandom_range(1, 3);
          end else begin
            ph = 0; grp = 1 - grp; left = $urandom_range(2, 8);
          end
        end
        left = left - 1;
        col  = (ph == 0) ? G : (ph == 1) ? Y : R;
        w    = (grp == 0) ? mk(col, R, col, R) : mk(R, col, R, col);
        if (inj_n == 0 && $urandom_range(0, 39) == 0) begin
          inj_n = $urandom_range(1, 3);
          inj_h = $urandom_range(0, NCH - 1);
          inj_c = 3'($urandom_range(0, 7));
        end
        if (inj_n > 0) begin
          w[3*inj_h +: 3] = inj_c;
          inj_n = inj_n - 1;
        end
        clr = ($urandom_range(0, 49) == 0);
      end
      if ($urandom_range(0, 599) == 0) rv = 1'b0;
      step(w, clr, rv);
    end
  endtask

  initial begin
    rst       = 1'b0;
    lights_in = ALLR;
    fault_clr = 1'b0;
    m_samp    = ALLR;
    m_fault   = 1'b0;
    m_code    = 3'd0;
    m_chan    = '0;
    m_cnt     = 8'd0;
    m_lights  = ALLR;
    m_age     = 0;
    forget_history();

    for (int i = 0; i < 3; i++) step(ALLR, 1'b0, 1'b0);
    hold(ALLR, 2);

    // Legal cycle on head 0
    hold(mk(R, R, R, R), 4);
    hold(mk(G, R, R, R), 10);
    hold(mk(Y, R, R, R), 3);
    hold(mk(R, R, R, R), 4);

    // Conflict, blocked clear, flash, then a valid clear
    hold(mk(G, Y, R, R), 3);
    step(mk(G, Y, R, R), 1'b1, 1'b1);
    hold(ALLR, 36);
    step(ALLR, 1'b1, 1'b1);
    hold(ALLR, 3);

    // Single-cycle glitch tolerated, two-cycle glitch faults
    hold(mk(R, R, 3'b110, R), 1);
    hold(ALLR, 3);
    hold(mk(R, R, 3'b110, R), 2);
    hold(ALLR, 4);
    step(ALLR, 1'b1, 1'b1);
    hold(ALLR, 2);

    // Green straight to red, then short yellow
    hold(mk(R, R, R, G), 2);
    hold(ALLR, 4);
    step(ALLR, 1'b1, 1'b1);
    hold(ALLR, 2);
    hold(mk(R, G, R, R), 2);
    hold(mk(R, Y, R, R), 2);
    hold(ALLR, 4);
    step(ALLR, 1'b1, 1'b1);
    hold(ALLR, 2);

    // Reset in the middle of flashing
    hold(mk(G, G, R, R), 1);
    hold(ALLR, 5);
    step(ALLR, 1'b0, 1'b0);
    hold(ALLR, 4);

    rand_run(4000);

    repeat (4) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
